// File: rtl/h_uart_rx.sv
// h_uart_rx -- serial receive end of the UART link.
//
// Deserialises 8N1 frames (5..8 data bits, LSB first) from an asynchronous
// idle-high rx line into parallel words. Each word is presented on a
// valid/ready port together with its framing/parity flags. An overrun flag
// reports words dropped because the held word was not consumed in time.
//
// Optional feature: define HUART_RX_PARITY_EN to add a parity bit after the
// data bits (even when PARITY_ODD=0, odd when PARITY_ODD=1). Without the
// macro there is no parity bit and o_parity_err is tied low.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx         serial line, idle high, asynchronous to i_clk
//   o_data_out   received word, bit 0 = first data bit on the line
//   o_out_valid  o_data_out and the error flags hold a word
//   i_out_ready  consumer accepts the word when valid && ready
//   o_frame_err  stop bit of the held word sampled low
//   o_parity_err parity mismatch on the held word
//   o_overrun    a word was dropped because the held word was not consumed
//   o_busy       receiver FSM is not idle
module h_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

`ifdef HUART_RX_PARITY_EN
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_brk;
    logic                 r_load_pend;
    logic                 r_stop_bit;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_out_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_cnt_half, w_cnt_full, w_idx_last;
    logic w_busy, w_smp_data, w_smp_stop, w_brk_clr;
    logic w_parity_err;

    assign w_cnt_half = (r_cnt == CNT_HALF);
    assign w_cnt_full = (r_cnt == CNT_FULL);
    assign w_idx_last = (r_idx == IDX_LAST);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // After a break (stop bit low) the line must go high before re-arming.
            S_IDLE:   if (!r_brk && !r_rxs) w_state_next = S_START;
            // A start bit that is gone by mid-bit was a glitch.
            S_START:  if (w_cnt_half) w_state_next = r_rxs ? S_IDLE : S_DATA;
            S_DATA:   if (w_cnt_full && w_idx_last) w_state_next = S_AFTER_DATA;
            S_PARITY: if (w_cnt_full) w_state_next = S_STOP;
            S_STOP:   if (w_cnt_full) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs / sampling strobes
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_smp_data = (r_state == S_DATA) && w_cnt_full;
        w_smp_stop = (r_state == S_STOP) && w_cnt_full;
        w_brk_clr  = (r_state == S_IDLE) && r_brk && r_rxs;
    end

    // Bit timing, shift register and break tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_brk       <= 1'b0;
            r_load_pend <= 1'b0;
            r_stop_bit  <= 1'b1;
        end else begin
            r_load_pend <= w_smp_stop;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                S_START: begin
                    r_cnt <= w_cnt_half ? '0 : r_cnt + 1'b1;
                    r_idx <= '0;
                end
                default: r_cnt <= w_cnt_full ? '0 : r_cnt + 1'b1;
            endcase
            if (w_smp_data) begin
                r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                r_idx   <= r_idx + 1'b1;
            end
            if (w_smp_stop) begin
                r_stop_bit <= r_rxs;
                if (!r_rxs) r_brk <= 1'b1;
            end else if (w_brk_clr) begin
                r_brk <= 1'b0;
            end
        end
    end

`ifdef HUART_RX_PARITY_EN
    logic r_pbit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                 r_pbit <= 1'b0;
        else if ((r_state == S_PARITY) && w_cnt_full) r_pbit <= r_rxs;
    end

    assign w_parity_err = ((^r_shift) ^ r_pbit) != PARITY_ODD[0];
`else
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD[0];
    assign w_parity_err        = 1'b0;
`endif

    // Output word register: loads one cycle after the stop-bit sample.
    // A handshake frees the slot; a load in the same cycle refills it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (r_load_pend) begin
                if (r_out_valid && !i_out_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data_out   <= r_shift;
                    r_frame_err  <= ~r_stop_bit;
                    r_parity_err <= w_parity_err;
                    r_out_valid  <= 1'b1;
                end
            end
        end
    end

    assign o_data_out   = r_data_out;
    assign o_out_valid  = r_out_valid;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_overrun    = r_overrun;
    assign o_busy       = w_busy;

endmodule

// File: tb/tb_h_uart_rx.sv
// Self-checking bench for h_uart_rx (CLKS_PER_BIT=4, DATA_BITS=8, even parity).
module tb_h_uart_rx;

    localparam int C = 4;
`ifdef HUART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] data_out;
    logic       out_valid, frame_err, parity_err, overrun, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } word_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         pflip;
        logic [7:0] exp_data;
        bit         exp_fe;
        bit         exp_pe;
    } vec_t;

    word_t got_q[$];

    h_uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .o_data_out   (data_out),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_frame_err  (frame_err),
        .o_parity_err (parity_err),
        .o_overrun    (overrun),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every word that is handed over (valid && ready seen mid-cycle).
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back('{data_out, frame_err, parity_err});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(C);
    endtask

    // Start bit, LSB-first data, optional parity (even, flipped on request), stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PEN) send_bit((^d) ^ pflip);
        send_bit(stop);
    endtask

    task automatic expect_word(input string tag, input logic [7:0] ed, input bit efe, input bit epe);
        word_t w;
        bit    ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (got_q.size() > 0) begin
                w  = got_q.pop_front();
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no word received, expected data 0x%0h", tag, ed);
        end else begin
            chk({tag, "_data"}, 32'(w.d), 32'(ed));
            chk({tag, "_fe"},   32'(w.fe), 32'(efe));
            chk({tag, "_pe"},   32'(w.pe), 32'(epe));
            $display("word %s: data=0x%02h fe=%0d pe=%0d", tag, w.d, w.fe, w.pe);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, PEN};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, PEN};

        // Reset with rx idle high.
        tick(3);
        chk("rst_busy_in_reset", 32'(busy), 0);
        rst_n = 1'b1;
        tick(100);
        chk("rst_data",    32'(data_out), 0);
        chk("rst_valid",   32'(out_valid), 0);
        chk("rst_fe",      32'(frame_err), 0);
        chk("rst_pe",      32'(parity_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_no_word", 32'(got_q.size()), 0);

        // Directed vector table.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].pflip);
            rx = 1'b1;
            tick(8);
            expect_word($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_fe, vecs[v].exp_pe);
            chk($sformatf("vec%0d_idle", v), 32'(busy), 0);
        end

        // Framing error followed by a held-low break, then a clean frame.
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40);
        expect_word("brk_first", 8'h3C, 1'b1, 1'b0);
        chk("brk_no_spurious", 32'(got_q.size()), 0);
        chk("brk_busy_low",    32'(busy), 0);
        rx = 1'b1;
        tick(4);
        send_frame(8'hA5, 1'b1, 1'b0);
        rx = 1'b1;
        tick(8);
        expect_word("brk_after", 8'hA5, 1'b0, 1'b0);

        // Overrun: consumer stalled across two frames.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        rx = 1'b1;
        tick(4);
        send_frame(8'h22, 1'b1, 1'b0);
        rx = 1'b1;
        tick(8);
        chk("ovr_valid",   32'(out_valid), 1);
        chk("ovr_data",    32'(data_out), 32'h11);
        chk("ovr_flag",    32'(overrun), 1);
        chk("ovr_no_word", 32'(got_q.size()), 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        chk("ovr_cleared",    32'(overrun), 0);
        chk("ovr_valid_low",  32'(out_valid), 0);
        expect_word("ovr_word", 8'h11, 1'b0, 1'b0);
        chk("ovr_single_word", 32'(got_q.size()), 0);
        out_ready = 1'b1;

        // One-cycle glitch on rx: start detected, rejected at mid-bit.
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        chk("glitch_busy_seen", 32'(busy), 1);
        tick(20);
        chk("glitch_idle",    32'(busy), 0);
        chk("glitch_no_word", 32'(got_q.size()), 0);

        // Reset in the middle of the data bits.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("mid_rst_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy_async", 32'(busy), 0);
        rx = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(60);
        chk("mid_rst_busy",    32'(busy), 0);
        chk("mid_rst_valid",   32'(out_valid), 0);
        chk("mid_rst_no_word", 32'(got_q.size()), 0);
        send_frame(8'h96, 1'b1, 1'b0);
        rx = 1'b1;
        tick(8);
        expect_word("mid_rst_recover", 8'h96, 1'b0, 1'b0);

        // Randomised frames against a parity/framing reference model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit         stop, pflip, pb, epe;
            d     = 8'($urandom_range(0, 255));
            stop  = ($urandom_range(0, 3) != 0);
            pflip = 1'($urandom_range(0, 1));
            // Transmitted parity bit makes the total count of ones even unless flipped.
            pb  = (($countones(d) % 2) == 1) ? ~pflip : pflip;
            epe = PEN ? ((($countones(d) + int'(pb)) % 2) != 0) : 1'b0;
            send_frame(d, stop, pflip);
            rx = 1'b1;
            tick(int'($urandom_range(2, 6)));
            expect_word($sformatf("rnd%0d", n), d, ~stop, epe);
        end

        tick(20);
        chk("final_no_extra", 32'(got_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/h_uart_rx.md
Name: h_uart_rx

Overview:
- Serial receive end of the system's UART link: deserialises 8N1 (optionally 8E1/8O1) frames on a single rx line into parallel bytes.
- Parity is checked with an XOR reduction over the received data bits plus the parity bit.
- Presents each byte on a valid/ready output port toward the CPU I/O register.
- Flags framing, parity and overrun errors alongside each byte.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (min 4); 100 MHz / 115200 baud.
- DATA_BITS, 8, data bits per frame (5..8).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored unless HUART_RX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  DATA_BITS  received byte; bit 0 is the first data bit on the line.
- out_valid  output  1  data_out and the error flags hold a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- frame_err  output  1  stop bit of the held word sampled low.
- parity_err  output  1  parity mismatch on the held word.
- overrun  output  1  a word was dropped because the held word was not consumed.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): data_out=0, out_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0. FSM goes to IDLE, counters clear, synchroniser flops set to 1.
- Reset mid-frame: the partial frame is discarded. No word or flag results from it.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Counter cnt has width clog2(CLKS_PER_BIT). Bit index idx has width clog2(DATA_BITS+1).
- IDLE:
  - On rxs==0, go to START with cnt=0.
  - If the brk flag is set, rxs==1 is required before re-arming; brk then clears.
- START:
  - When cnt == CLKS_PER_BIT/2-1, sample rxs (mid-bit).
  - rxs==1 means a glitch: return to IDLE, no word, no flag.
  - Otherwise go to DATA with cnt=0, idx=0.
- DATA:
  - When cnt == CLKS_PER_BIT-1, sample rxs into the shift register LSB-first, increment idx, cnt=0.
  - After DATA_BITS samples, go to PARITY (macro defined) or STOP.
- PARITY: sample after CLKS_PER_BIT cycles into pbit, then go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles.
  - stop=0 sets the word's frame_err and sets brk.
  - Load the word, then go to IDLE.
- Word load:
  - Happens in the cycle after the stop-bit sample, so out_valid rises 1 cycle after that sample.
  - Total delay from the start-bit edge on rx is about (1.5 + DATA_BITS [+1]) x CLKS_PER_BIT + 3 cycles.
  - data_out, frame_err and parity_err update together.
- Handshake:
  - data_out and the flags stay stable while out_valid=1 && out_ready=0.
  - out_valid clears on the cycle after the handshake unless a new word loads in the same cycle.
- Word completes while out_valid=1 and out_ready=0:
  - The new word is dropped, the held word is kept, and overrun is set.
  - overrun clears on the next handshake.
- Word completes in the same cycle as a handshake: the new word loads, out_valid stays 1, no overrun.
- Receiving continues regardless of the output port state. The FSM never stalls.

Optional Feature:
- Macro: HUART_RX_PARITY_EN.
- Defined:
  - The frame includes a parity bit and the PARITY state is active.
  - parity_err = (XOR of data bits XOR pbit) != PARITY_ODD.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - parity_err is tied 0 and PARITY_ODD is unused.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Reset, rx held high for 100 cycles -> all outputs 0, busy=0.
- Frame 0x5A with stop=1, out_ready=1 -> one out_valid pulse, data_out=0x5A, frame_err=0, parity_err=0.
- With the macro, even parity:
  - 0x07 with parity bit 1 -> parity_err=0.
  - 0x07 with parity bit 0 -> parity_err=1, data_out=0x07.
- 0x3C with stop bit 0, then rx held low 40 cycles, then high, then 0xA5:
  - First word 0x3C with frame_err=1.
  - No spurious word while rx is held low.
  - Then 0xA5 with frame_err=0.
- out_ready=0; send 0x11 then 0x22 -> data_out stays 0x11, overrun=1. Pulse out_ready -> overrun=0, out_valid=0.
- rx low pulse of 1 cycle, and separately a rst_n pulse mid-DATA -> no word, FSM back to IDLE, busy=0.
